issue_rat_freelist: RTL
=======================

Name: issue_rat_freelist

Overview:
- Circular FIFO of free physical registers (PRFs) for the 64-entry RAT.
- Hands out PRFs to rename and reports every allocation, tagged with its FGR, to the freelist checkpoint over the acquired handshake.
- Reclaims PRFs from two sources: the checkpoint's abandoned port (speculative rollback) and the retire-release port (old mappings freed at commit).
- After reset, an init FSM loads every non-architectural PRF before the block accepts traffic.

Parameters:
- PRF_WIDTH, 6: PRF index width.
- FGR_WIDTH, 4: FGR tag width.
- ARF_COUNT, 32: PRFs 0..ARF_COUNT-1 are architecturally mapped at reset; DEPTH = 2^PRF_WIDTH - ARF_COUNT must be a power of two (default 32).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_alloc_valid  in  1  rename requests one PRF.
- o_alloc_ready  out  1  allocation fires this cycle.
- i_alloc_fgr  in  FGR_WIDTH  FGR of the requesting group.
- o_alloc_prf  out  PRF_WIDTH  PRF handed out (head entry).
- o_acquired_valid  out  1  allocation report to checkpoint.
- i_acquired_ready  in  1  checkpoint accepts report.
- o_acquired_fgr  out  FGR_WIDTH  equals i_alloc_fgr.
- o_acquired_prf  out  PRF_WIDTH  equals o_alloc_prf.
- i_abandoned_valid  in  1  checkpoint returns a PRF.
- o_abandoned_ready  out  1  return accepted.
- i_abandoned_prf  in  PRF_WIDTH  returned PRF.
- i_release_valid  in  1  retire frees a PRF.
- o_release_ready  out  1  release accepted.
- i_release_prf  in  PRF_WIDTH  released PRF.
- o_free_count  out  PRF_WIDTH  current occupancy (0..DEPTH).
- o_error  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- State: storage DEPTH x PRF_WIDTH; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count register PRF_WIDTH bits; FSM {INIT, RUN}; init index register.
- Reset (asynchronous): FSM=INIT, head=tail=count=init index=0, o_error=0.
  - All readies and o_acquired_valid are 0 while reset is asserted and throughout INIT.
  - o_free_count=0.
- INIT:
  - Each cycle writes ARF_COUNT+k into entry k, then count++, tail++.
  - After DEPTH cycles (k=DEPTH-1 written): count=DEPTH, tail wrapped to 0, FSM->RUN.
  - The first RUN cycle is DEPTH cycles after reset deassertion.
  - Inputs are ignored during INIT.
- Reset asserted mid-operation aborts everything and restarts INIT; contents are rebuilt and nothing is retained.
- RUN, allocation:
  - o_acquired_valid = i_alloc_valid & (count != 0).
  - o_alloc_ready = o_acquired_valid & i_acquired_ready.
  - o_acquired_valid must not depend on i_acquired_ready.
  - o_alloc_prf / o_acquired_prf = storage[head], combinational.
  - On fire: head++ and the entry is consumed; both sides see the transfer in the same cycle.
- RUN, returns:
  - o_abandoned_ready = o_release_ready = 1.
  - Pushes in one cycle:
    - abandoned only: storage[tail], tail += 1.
    - release only: storage[tail], tail += 1.
    - both: abandoned at tail, release at tail+1, tail += 2.
  - Written data is visible at head no earlier than the next cycle; no same-cycle bypass, so an empty list stays non-ready even when a push arrives that cycle.
- Count: count_next = count + abandoned_fire + release_fire - alloc_fire, evaluated in one cycle.
  - Push and pop in the same cycle at a nonempty list are both allowed.
  - A pop at count=1 with a push in the same cycle leaves count=1.
- Overflow (count_next > DEPTH) is a protocol violation: double free or a bad PRF. Pointers and count behave as modulo arithmetic; the only defined reaction is o_error per the optional feature.
- No PRF-range check on inputs; returned values are stored verbatim.

Optional Feature:
- Macro ISSUE_RAT_FREELIST_OVERFLOW_CHECK_EN.
- Defined: o_error is set when the current count + abandoned_fire + release_fire - alloc_fire would exceed DEPTH.
  - Set one cycle after the offending cycle; sticky until reset.
  - On overflow the pushes are dropped: tail and count unchanged by pushes, while the pop still proceeds.
- Undefined: o_error tied to 0; overflow pushes wrap unchecked.

Test Plan:
- Reset, then wait 32 cycles -> RUN entered on cycle 32, o_free_count=32. Allocate 32 consecutive cycles with i_acquired_ready=1, fgr=3 -> o_alloc_prf = 32,33,...,63, o_acquired_fgr=3 each cycle, then o_alloc_ready=0 at count 0.
- Backpressure: i_alloc_valid=1, i_acquired_ready=0 for 3 cycles -> o_acquired_valid=1, o_alloc_ready=0, head stays (prf 32 held). Then ready=1 -> prf 32 fires once.
- Dual return at empty list: abandoned prf 40 + release prf 50 in the same cycle as an alloc request -> no alloc that cycle. Next cycle count=2, allocations return 40 then 50.
- Simultaneous pop+2 pushes at count=5 -> count=6 next cycle. Wrap test: cycle 100 allocs and returns -> FIFO order preserved across pointer wrap.
- Reset pulse mid-stream at count=17 -> all readies 0 immediately (async), INIT reruns, after 32 cycles head reads 32.
- With ISSUE_RAT_FREELIST_OVERFLOW_CHECK_EN at count=32, release prf 5 without alloc -> o_error=1 next cycle, count stays 32. Without the macro, o_error stays 0.

Source files
------------

// File: rtl/issue_rat_freelist.sv
// ----------------------------------------------------------------------------
// issue_rat_freelist
//
// Circular FIFO of free physical registers for the register alias table.
// PRFs 0..ARF_COUNT-1 hold the architectural state at reset; the remaining
// DEPTH = 2**PRF_WIDTH - ARF_COUNT PRFs are loaded into the list by an init
// sequencer (one entry per cycle) before any traffic is accepted.
//
// Rename pops one PRF per cycle. Every pop is reported, tagged with the
// requesting FGR, to the freelist checkpoint over the acquired handshake.
// The pop and the report are one transfer: they fire together or not at all.
// PRFs come back from two sources per cycle: the checkpoint's abandoned port
// (speculative rollback) and the retire release port (old mappings freed at
// commit). When both arrive together, abandoned goes first.
//
// Optional feature, selected by the macro ISSUE_RAT_FREELIST_OVERFLOW_CHECK_EN:
//   defined   - an occupancy overflow (double free / bogus PRF) drops that
//               cycle's pushes and sets the sticky o_error one cycle later.
//   undefined - o_error is tied low and overflowing pushes wrap unchecked.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   i_alloc_valid         rename requests one PRF
//   o_alloc_ready         allocation fires this cycle
//   i_alloc_fgr           FGR of the requesting group
//   o_alloc_prf           PRF at the head of the list (combinational)
//   o_acquired_valid      allocation report to the checkpoint
//   i_acquired_ready      checkpoint accepts the report
//   o_acquired_fgr/prf    report payload (mirrors i_alloc_fgr / o_alloc_prf)
//   i_abandoned_valid/prf checkpoint returns a PRF; o_abandoned_ready accepts
//   i_release_valid/prf   retire frees a PRF;     o_release_ready accepts
//   o_free_count          number of PRFs in the list (0..DEPTH)
//   o_error               sticky overflow flag
// ----------------------------------------------------------------------------
module issue_rat_freelist #(
    parameter int PRF_WIDTH = 6,
    parameter int FGR_WIDTH = 4,
    parameter int ARF_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 i_alloc_valid,
    output logic                 o_alloc_ready,
    input  logic [FGR_WIDTH-1:0] i_alloc_fgr,
    output logic [PRF_WIDTH-1:0] o_alloc_prf,

    output logic                 o_acquired_valid,
    input  logic                 i_acquired_ready,
    output logic [FGR_WIDTH-1:0] o_acquired_fgr,
    output logic [PRF_WIDTH-1:0] o_acquired_prf,

    input  logic                 i_abandoned_valid,
    output logic                 o_abandoned_ready,
    input  logic [PRF_WIDTH-1:0] i_abandoned_prf,

    input  logic                 i_release_valid,
    output logic                 o_release_ready,
    input  logic [PRF_WIDTH-1:0] i_release_prf,

    output logic [PRF_WIDTH-1:0] o_free_count,
    output logic                 o_error
);

    localparam int DEPTH = (1 << PRF_WIDTH) - ARF_COUNT;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_reg, state_next;
    logic [PTR_W-1:0]     head_reg, head_next;
    logic [PTR_W-1:0]     tail_reg, tail_next;
    logic [PTR_W-1:0]     init_idx_reg, init_idx_next;
    logic [PRF_WIDTH-1:0] count_reg, count_next;

    // Storage is read combinationally at the head, so it maps to
    // distributed RAM / registers rather than a registered-read block RAM.
    logic [PRF_WIDTH-1:0] mem [DEPTH];

    // Two write ports: port 0 serves the init loader or the first push,
    // port 1 serves the release push when both returns arrive together.
    logic                 we0, we1;
    logic [PTR_W-1:0]     wa0, wa1;
    logic [PRF_WIDTH-1:0] wd0, wd1;
    logic [DEPTH-1:0]     wr_sel0, wr_sel1;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic       run;
    logic       alloc_fire;
    logic       abandoned_fire;
    logic       release_fire;
    logic [1:0] push_cnt;
    logic       push_ok;

    assign run = (state_reg == ST_RUN);

    // Valid towards the checkpoint depends only on the request and on the
    // list being nonempty, never on i_acquired_ready.
    assign o_acquired_valid  = run & i_alloc_valid & (count_reg != '0);
    assign alloc_fire        = o_acquired_valid & i_acquired_ready;
    assign o_alloc_ready     = alloc_fire;

    assign o_abandoned_ready = run;
    assign o_release_ready   = run;
    assign abandoned_fire    = run & i_abandoned_valid;
    assign release_fire      = run & i_release_valid;
    assign push_cnt          = {1'b0, abandoned_fire} + {1'b0, release_fire};

    assign o_alloc_prf       = mem[head_reg];
    assign o_acquired_prf    = mem[head_reg];
    assign o_acquired_fgr    = i_alloc_fgr;
    assign o_free_count      = count_reg;

`ifdef ISSUE_RAT_FREELIST_OVERFLOW_CHECK_EN
    // Occupancy after this cycle, one bit wider so values above DEPTH are
    // representable. A pop only fires when count is nonzero, so the
    // subtraction cannot underflow.
    logic [PRF_WIDTH:0] occ_next_ext;
    logic               overflow;
    logic               error_reg, error_next;

    assign occ_next_ext = {1'b0, count_reg}
                        + (PRF_WIDTH+1)'(push_cnt)
                        - (PRF_WIDTH+1)'(alloc_fire);
    assign overflow     = run & (occ_next_ext > (PRF_WIDTH+1)'(DEPTH));
    assign push_ok      = ~overflow;
    assign error_next   = error_reg | overflow;
    assign o_error      = error_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_reg <= 1'b0;
        end else begin
            error_reg <= error_next;
        end
    end
`else
    assign push_ok = 1'b1;
    assign o_error = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic (FSM + pointers + write ports)
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        init_idx_next = init_idx_reg;
        count_next    = count_reg;
        we0           = 1'b0;
        we1           = 1'b0;
        wa0           = tail_reg;
        wa1           = tail_reg + PTR_W'(1);
        wd0           = i_release_prf;
        wd1           = i_release_prf;

        case (state_reg)
            ST_INIT: begin
                // Entry k receives PRF ARF_COUNT+k; all inputs are ignored.
                we0           = 1'b1;
                wa0           = init_idx_reg;
                wd0           = PRF_WIDTH'(ARF_COUNT) + PRF_WIDTH'(init_idx_reg);
                count_next    = count_reg + PRF_WIDTH'(1);
                tail_next     = tail_reg + PTR_W'(1);
                init_idx_next = init_idx_reg + PTR_W'(1);
                if (init_idx_reg == PTR_W'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                head_next = head_reg + PTR_W'(alloc_fire);
                if (push_ok) begin
                    we0        = abandoned_fire | release_fire;
                    wd0        = abandoned_fire ? i_abandoned_prf : i_release_prf;
                    we1        = abandoned_fire & release_fire;
                    tail_next  = tail_reg + PTR_W'(push_cnt);
                    count_next = count_reg + PRF_WIDTH'(push_cnt)
                               - PRF_WIDTH'(alloc_fire);
                end else begin
                    // Overflowing pushes are dropped; the pop still proceeds.
                    count_next = count_reg - PRF_WIDTH'(alloc_fire);
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            head_reg     <= '0;
            tail_reg     <= '0;
            init_idx_reg <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            init_idx_reg <= init_idx_next;
            count_reg    <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage: per-entry write selects, then one write process.
    // The two ports never target the same entry in one cycle.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
        assign wr_sel0[gi] = we0 & (wa0 == PTR_W'(gi));
        assign wr_sel1[gi] = we1 & (wa1 == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel0[i]) begin
                mem[i] <= wd0;
            end else if (wr_sel1[i]) begin
                mem[i] <= wd1;
            end
        end
    end

endmodule
